// File: rtl/qix_cpu_mailbox.sv
// qix_cpu_mailbox: cross-CPU mailbox and FIRQ block between the Qix data CPU
// (side A) and the video CPU (side B). Each direction carries NCH channels, and
// each channel has a data byte, a pending flag, an overflow flag and a
// maskable FIRQ. FIRQ runs as a level (MODE 0) or a stretched pulse (MODE 1).
//
// Ports (side A shown; side B is identical with the b_ prefix):
//   clk_20m   in   system clock
//   reset     in   synchronous, active-high
//   a_E       in   6809E E clock (sampled on clk_20m)
//   a_cs      in   chip select
//   a_rnw     in   read/not-write
//   a_addr    in   register offset [AW-1:0]
//   a_din     in   write data [7:0]
//   a_dout    out  read data [7:0], combinational, 8'hFF when not selected
//   a_firq_n  out  FIRQ to side-A CPU, active low, registered
//   a_pend    out  incoming-pending vector of side A [NCH-1:0] (debug)
//
// Register map per side (k = channel):
//   2k      W: post byte to other side     R: incoming byte
//   2k+1    W: ack own incoming channel    R: {pend_in, ovf_in, pend_out, 5'b0}
//   2*NCH   W: mask                        R: mask zero-extended
//   other   W: ignored                     R: 8'hFF
module qix_cpu_mailbox #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned MODE      = 0,
    parameter int unsigned PULSE_LEN = 16,
    parameter int unsigned AW        = 4
) (
    input  logic           clk_20m,
    input  logic           reset,
    input  logic           a_E,
    input  logic           a_cs,
    input  logic           a_rnw,
    input  logic [AW-1:0]  a_addr,
    input  logic [7:0]     a_din,
    output logic [7:0]     a_dout,
    output logic           a_firq_n,
    input  logic           b_E,
    input  logic           b_cs,
    input  logic           b_rnw,
    input  logic [AW-1:0]  b_addr,
    input  logic [7:0]     b_din,
    output logic [7:0]     b_dout,
    output logic           b_firq_n,
    output logic [NCH-1:0] a_pend,
    output logic [NCH-1:0] b_pend
);

    localparam int unsigned CW       = $clog2(PULSE_LEN + 1);
    localparam int unsigned MASK_OFS = 2 * NCH;

    // State: mbox_ab carries A->B bytes; pend_b/ovf_b are B's incoming flags.
    logic                  r_a_e_prev, r_b_e_prev;
    logic [NCH-1:0][7:0]   r_mbox_ab, r_mbox_ba;
    logic [NCH-1:0]        r_pend_a, r_pend_b;
    logic [NCH-1:0]        r_ovf_a, r_ovf_b;
    logic [NCH-1:0]        r_mask_a, r_mask_b;
    logic [CW-1:0]         r_cnt_a, r_cnt_b;
    logic                  r_a_firq_n, r_b_firq_n;

    logic                  w_a_wr, w_b_wr;
    logic [NCH-1:0]        w_a_post, w_a_ack, w_b_post, w_b_ack;
    logic                  w_a_mask_wr, w_b_mask_wr;
    logic [NCH-1:0]        w_pend_a_nxt, w_pend_b_nxt;
    logic [NCH-1:0]        w_ovf_a_nxt, w_ovf_b_nxt;
    logic [NCH-1:0]        w_mask_a_nxt, w_mask_b_nxt;
    logic [CW-1:0]         w_cnt_a_nxt, w_cnt_b_nxt;
    logic                  w_a_firq_n_nxt, w_b_firq_n_nxt;

    // Read mux for one side; cs low floats the bus to 8'hFF.
    function automatic logic [7:0] f_rd(
        input logic                cs,
        input logic [AW-1:0]       addr,
        input logic [NCH-1:0][7:0] mbox_in,
        input logic [NCH-1:0]      pend_in,
        input logic [NCH-1:0]      ovf_in,
        input logic [NCH-1:0]      pend_out,
        input logic [NCH-1:0]      mask
    );
        logic [7:0] v;
        v = 8'hFF;
        if (cs) begin
            for (int k = 0; k < NCH; k++) begin
                if (addr == AW'(2 * k))     v = mbox_in[k];
                if (addr == AW'(2 * k + 1)) v = {pend_in[k], ovf_in[k], pend_out[k], 5'b0};
            end
            if (addr == AW'(MASK_OFS)) v = 8'(mask);
        end
        return v;
    endfunction

    // One strobe per bus write, on the E falling edge.
    assign w_a_wr = r_a_e_prev & ~a_E & a_cs & ~a_rnw;
    assign w_b_wr = r_b_e_prev & ~b_E & b_cs & ~b_rnw;

    // Address decode of the write strobes.
    always_comb begin
        w_a_post    = '0;
        w_a_ack     = '0;
        w_b_post    = '0;
        w_b_ack     = '0;
        w_a_mask_wr = w_a_wr && (a_addr == AW'(MASK_OFS));
        w_b_mask_wr = w_b_wr && (b_addr == AW'(MASK_OFS));
        for (int k = 0; k < NCH; k++) begin
            w_a_post[k] = w_a_wr && (a_addr == AW'(2 * k));
            w_a_ack[k]  = w_a_wr && (a_addr == AW'(2 * k + 1));
            w_b_post[k] = w_b_wr && (b_addr == AW'(2 * k));
            w_b_ack[k]  = w_b_wr && (b_addr == AW'(2 * k + 1));
        end
    end

    // Next state: an ack is applied before a same-cycle post, so the pair
    // leaves pend=1 with no overflow.
    always_comb begin
        w_pend_a_nxt = (r_pend_a & ~w_a_ack) | w_b_post;
        w_pend_b_nxt = (r_pend_b & ~w_b_ack) | w_a_post;
        w_ovf_a_nxt  = (r_ovf_a & ~w_a_ack) | (w_b_post & r_pend_a & ~w_a_ack);
        w_ovf_b_nxt  = (r_ovf_b & ~w_b_ack) | (w_a_post & r_pend_b & ~w_b_ack);
        w_mask_a_nxt = w_a_mask_wr ? a_din[NCH-1:0] : r_mask_a;
        w_mask_b_nxt = w_b_mask_wr ? b_din[NCH-1:0] : r_mask_b;

        w_cnt_a_nxt = (r_cnt_a != '0) ? r_cnt_a - CW'(1) : '0;
        w_cnt_b_nxt = (r_cnt_b != '0) ? r_cnt_b - CW'(1) : '0;
        if (|(w_b_post & w_mask_a_nxt)) w_cnt_a_nxt = CW'(PULSE_LEN);
        if (|(w_a_post & w_mask_b_nxt)) w_cnt_b_nxt = CW'(PULSE_LEN);

        // FIRQ is registered from next state so it moves with the flag edge.
        if (MODE == 0) begin
            w_a_firq_n_nxt = ~|(w_pend_a_nxt & w_mask_a_nxt);
            w_b_firq_n_nxt = ~|(w_pend_b_nxt & w_mask_b_nxt);
        end else begin
            w_a_firq_n_nxt = (w_cnt_a_nxt == '0);
            w_b_firq_n_nxt = (w_cnt_b_nxt == '0);
        end
    end

    // State registers.
    always_ff @(posedge clk_20m) begin
        if (reset) begin
            r_a_e_prev <= 1'b0;
            r_b_e_prev <= 1'b0;
            r_mbox_ab  <= '0;
            r_mbox_ba  <= '0;
            r_pend_a   <= '0;
            r_pend_b   <= '0;
            r_ovf_a    <= '0;
            r_ovf_b    <= '0;
            r_mask_a   <= '1;
            r_mask_b   <= '1;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_a_firq_n <= 1'b1;
            r_b_firq_n <= 1'b1;
        end else begin
            r_a_e_prev <= a_E;
            r_b_e_prev <= b_E;
            for (int k = 0; k < NCH; k++) begin
                if (w_a_post[k]) r_mbox_ab[k] <= a_din;
                if (w_b_post[k]) r_mbox_ba[k] <= b_din;
            end
            r_pend_a   <= w_pend_a_nxt;
            r_pend_b   <= w_pend_b_nxt;
            r_ovf_a    <= w_ovf_a_nxt;
            r_ovf_b    <= w_ovf_b_nxt;
            r_mask_a   <= w_mask_a_nxt;
            r_mask_b   <= w_mask_b_nxt;
            r_cnt_a    <= w_cnt_a_nxt;
            r_cnt_b    <= w_cnt_b_nxt;
            r_a_firq_n <= w_a_firq_n_nxt;
            r_b_firq_n <= w_b_firq_n_nxt;
        end
    end

    assign a_dout   = f_rd(a_cs, a_addr, r_mbox_ba, r_pend_a, r_ovf_a, r_pend_b, r_mask_a);
    assign b_dout   = f_rd(b_cs, b_addr, r_mbox_ab, r_pend_b, r_ovf_b, r_pend_a, r_mask_b);
    assign a_firq_n = r_a_firq_n;
    assign b_firq_n = r_b_firq_n;
    assign a_pend   = r_pend_a;
    assign b_pend   = r_pend_b;

endmodule

// File: tb/tb_qix_cpu_mailbox.sv
// Bench for qix_cpu_mailbox: a level-mode and a pulse-mode instance share the
// same bus stimulus; register reads are checked through an expected-read queue.
module tb_qix_cpu_mailbox;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_E, a_cs, a_rnw, b_E, b_cs, b_rnw;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_din, b_din;
    logic [7:0] a_dout0, b_dout0, a_dout1, b_dout1;
    logic       a_firq_n0, b_firq_n0, a_firq_n1, b_firq_n1;
    logic [1:0] a_pend0, b_pend0, a_pend1, b_pend1;

    int n_cmp = 0;
    int n_bad = 0;

    // FIRQ values sampled in the strobe cycle of the last bus write.
    logic strb_b0, strb_b1;

    typedef struct {
        bit         inst;
        bit         side;
        logic [3:0] addr;
        logic [7:0] exp;
        string      name;
    } rd_t;
    rd_t rd_q[$];

    always #5 clk = ~clk;

    qix_cpu_mailbox #(.NCH(2), .MODE(0), .PULSE_LEN(16), .AW(4)) u_lvl (
        .clk_20m(clk), .reset(reset),
        .a_E(a_E), .a_cs(a_cs), .a_rnw(a_rnw), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout0), .a_firq_n(a_firq_n0),
        .b_E(b_E), .b_cs(b_cs), .b_rnw(b_rnw), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout0), .b_firq_n(b_firq_n0),
        .a_pend(a_pend0), .b_pend(b_pend0)
    );

    qix_cpu_mailbox #(.NCH(2), .MODE(1), .PULSE_LEN(16), .AW(4)) u_pls (
        .clk_20m(clk), .reset(reset),
        .a_E(a_E), .a_cs(a_cs), .a_rnw(a_rnw), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout1), .a_firq_n(a_firq_n1),
        .b_E(b_E), .b_cs(b_cs), .b_rnw(b_rnw), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout1), .b_firq_n(b_firq_n1),
        .a_pend(a_pend1), .b_pend(b_pend1)
    );

    function automatic void exp_rd(input bit inst, input bit side, input logic [3:0] addr,
                                   input logic [7:0] e, input string name);
        rd_t r;
        r.inst = inst; r.side = side; r.addr = addr; r.exp = e; r.name = name;
        rd_q.push_back(r);
    endfunction

    // Write cycle on either or both sides with aligned E falls; returns at the
    // negedge just after the clock edge that consumed the strobe.
    task automatic bus_cycle(input bit aen, input logic [3:0] aad, input logic [7:0] ad,
                             input bit ben, input logic [3:0] bad, input logic [7:0] bd);
        @(negedge clk);
        if (aen) begin a_cs = 1; a_rnw = 0; a_addr = aad; a_din = ad; a_E = 1; end
        if (ben) begin b_cs = 1; b_rnw = 0; b_addr = bad; b_din = bd; b_E = 1; end
        @(negedge clk);
        a_E = 0; b_E = 0;
        #1;
        strb_b0 = b_firq_n0;
        strb_b1 = b_firq_n1;
        @(negedge clk);
        a_cs = 0; a_rnw = 1; b_cs = 0; b_rnw = 1;
    endtask

    task automatic bus_wr(input bit side, input logic [3:0] addr, input logic [7:0] d);
        if (side) bus_cycle(0, 4'h0, 8'h00, 1, addr, d);
        else      bus_cycle(1, addr, d, 0, 4'h0, 8'h00);
    endtask

    // Read cycle with a full E pulse; returns the side's dout of both instances.
    task automatic bus_rd(input bit side, input logic [3:0] addr,
                          output logic [7:0] d0, output logic [7:0] d1);
        @(negedge clk);
        if (side) begin b_cs = 1; b_rnw = 1; b_addr = addr; b_E = 1; end
        else      begin a_cs = 1; a_rnw = 1; a_addr = addr; a_E = 1; end
        @(negedge clk);
        a_E = 0; b_E = 0;
        #1;
        d0 = side ? b_dout0 : a_dout0;
        d1 = side ? b_dout1 : a_dout1;
        @(negedge clk);
        a_cs = 0; b_cs = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rd_t r; logic [7:0] d0, d1, got;
        do_reset();
        n_cmp++; if (a_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL rst_a_firq: got %b expected 1", a_firq_n0); end
        n_cmp++; if (b_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL rst_b_firq: got %b expected 1", b_firq_n0); end
        n_cmp++; if (b_firq_n1 !== 1'b1) begin n_bad++; $display("FAIL rst_b_firq_pulse: got %b expected 1", b_firq_n1); end
        n_cmp++; if ({a_pend0, b_pend0} !== 4'b0) begin n_bad++; $display("FAIL rst_pend: got %b expected 0000", {a_pend0, b_pend0}); end
        n_cmp++; if (a_dout0 !== 8'hFF) begin n_bad++; $display("FAIL rst_cs_low_dout: got %02h expected ff", a_dout0); end
        exp_rd(0, 0, 4'd4, 8'h03, "rst_a_mask");
        exp_rd(0, 1, 4'd4, 8'h03, "rst_b_mask");
        exp_rd(0, 0, 4'd1, 8'h00, "rst_a_stat0");
        exp_rd(0, 1, 4'd3, 8'h00, "rst_b_stat1");
        exp_rd(0, 0, 4'd0, 8'h00, "rst_a_mbox0");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        // Write cycle held across reset with E dropping at release: no strobe.
        @(negedge clk);
        reset = 1; a_E = 1; a_cs = 1; a_rnw = 0; a_addr = 4'd0; a_din = 8'h99;
        repeat (2) @(negedge clk);
        reset = 0; a_E = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (b_pend0 !== 2'b00) begin n_bad++; $display("FAIL rst_no_spurious: b_pend %b expected 00", b_pend0); end
        a_cs = 0; a_rnw = 1;
        // E held high across release, falling afterwards: strobe fires.
        @(negedge clk);
        reset = 1; a_E = 1; a_cs = 1; a_rnw = 0; a_addr = 4'd0; a_din = 8'hA5;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        n_cmp++; if (b_pend0 !== 2'b00) begin n_bad++; $display("FAIL straddle_early: b_pend %b expected 00", b_pend0); end
        a_E = 0;
        @(negedge clk);
        n_cmp++; if (b_pend0 !== 2'b01) begin n_bad++; $display("FAIL straddle_post: b_pend %b expected 01", b_pend0); end
        a_cs = 0; a_rnw = 1;
        exp_rd(0, 1, 4'd0, 8'hA5, "straddle_data");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        do_reset();
        n_cmp++; if (b_pend0 !== 2'b00) begin n_bad++; $display("FAIL rst_clears_pend: b_pend %b expected 00", b_pend0); end
    endtask

    task automatic test_post_ack();
        rd_t r; logic [7:0] d0, d1, got;
        bus_wr(0, 4'd0, 8'h5A);
        n_cmp++; if (strb_b0 !== 1'b1) begin n_bad++; $display("FAIL post_firq_strobe_cycle: got %b expected 1", strb_b0); end
        n_cmp++; if (b_firq_n0 !== 1'b0) begin n_bad++; $display("FAIL post_firq_low: got %b expected 0", b_firq_n0); end
        n_cmp++; if (a_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL post_a_firq_quiet: got %b expected 1", a_firq_n0); end
        n_cmp++; if (b_pend0 !== 2'b01) begin n_bad++; $display("FAIL post_b_pend: got %b expected 01", b_pend0); end
        exp_rd(0, 1, 4'd0, 8'h5A, "post_b_data");
        exp_rd(0, 1, 4'd1, 8'h80, "post_b_status");
        exp_rd(0, 0, 4'd1, 8'h20, "post_a_status");
        exp_rd(0, 0, 4'd0, 8'h00, "post_a_data");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(1, 4'd1, 8'hFF);
        n_cmp++; if (b_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL ack_firq_high: got %b expected 1", b_firq_n0); end
        n_cmp++; if (b_pend0 !== 2'b00) begin n_bad++; $display("FAIL ack_b_pend: got %b expected 00", b_pend0); end
        exp_rd(0, 1, 4'd1, 8'h00, "ack_b_status");
        exp_rd(0, 0, 4'd1, 8'h00, "ack_a_status");
        exp_rd(0, 1, 4'd0, 8'h5A, "ack_keeps_data");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        // Reverse direction on channel 1.
        bus_wr(1, 4'd2, 8'h3C);
        n_cmp++; if (a_firq_n0 !== 1'b0) begin n_bad++; $display("FAIL rev_a_firq_low: got %b expected 0", a_firq_n0); end
        n_cmp++; if (a_pend0 !== 2'b10) begin n_bad++; $display("FAIL rev_a_pend: got %b expected 10", a_pend0); end
        exp_rd(0, 0, 4'd2, 8'h3C, "rev_a_data");
        exp_rd(0, 0, 4'd3, 8'h80, "rev_a_status");
        exp_rd(0, 1, 4'd3, 8'h20, "rev_b_status");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(0, 4'd3, 8'h00);
        n_cmp++; if (a_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL rev_ack_firq: got %b expected 1", a_firq_n0); end
    endtask

    task automatic test_overflow();
        rd_t r; logic [7:0] d0, d1, got;
        bus_wr(0, 4'd2, 8'h11);
        bus_wr(0, 4'd2, 8'h22);
        exp_rd(0, 1, 4'd2, 8'h22, "ovf_data");
        exp_rd(0, 1, 4'd3, 8'hC0, "ovf_status");
        exp_rd(0, 0, 4'd3, 8'h20, "ovf_a_status");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(1, 4'd3, 8'h00);
        exp_rd(0, 1, 4'd3, 8'h00, "ovf_ack_status");
        exp_rd(0, 0, 4'd3, 8'h00, "ovf_ack_a_status");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
    endtask

    task automatic test_mask();
        rd_t r; logic [7:0] d0, d1, got;
        bus_wr(1, 4'd4, 8'h02);
        bus_wr(0, 4'd0, 8'h77);
        n_cmp++; if (b_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL mask_firq_held: got %b expected 1", b_firq_n0); end
        n_cmp++; if (b_pend0 !== 2'b01) begin n_bad++; $display("FAIL mask_pend: got %b expected 01", b_pend0); end
        exp_rd(0, 1, 4'd4, 8'h02, "mask_b_read");
        exp_rd(0, 1, 4'd1, 8'h80, "mask_b_status");
        exp_rd(0, 0, 4'd4, 8'h03, "mask_a_unchanged");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(1, 4'd4, 8'h03);
        n_cmp++; if (strb_b0 !== 1'b1) begin n_bad++; $display("FAIL unmask_strobe_cycle: got %b expected 1", strb_b0); end
        n_cmp++; if (b_firq_n0 !== 1'b0) begin n_bad++; $display("FAIL unmask_firq_low: got %b expected 0", b_firq_n0); end
        bus_wr(1, 4'd4, 8'h02);
        n_cmp++; if (b_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL remask_firq_high: got %b expected 1", b_firq_n0); end
        bus_wr(1, 4'd4, 8'h03);
        bus_wr(1, 4'd1, 8'h00);
        n_cmp++; if (b_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL mask_ack_firq: got %b expected 1", b_firq_n0); end
        // Mask write in the same cycle as a post.
        bus_cycle(1, 4'd0, 8'h88, 1, 4'd4, 8'h00);
        n_cmp++; if (b_pend0 !== 2'b01) begin n_bad++; $display("FAIL maskpost_pend: got %b expected 01", b_pend0); end
        n_cmp++; if (b_firq_n0 !== 1'b1) begin n_bad++; $display("FAIL maskpost_firq: got %b expected 1", b_firq_n0); end
        exp_rd(0, 1, 4'd4, 8'h00, "maskpost_mask");
        exp_rd(0, 1, 4'd0, 8'h88, "maskpost_data");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(1, 4'd4, 8'h03);
        n_cmp++; if (b_firq_n0 !== 1'b0) begin n_bad++; $display("FAIL maskpost_unmask: got %b expected 0", b_firq_n0); end
        bus_wr(1, 4'd1, 8'h00);
    endtask

    task automatic test_same_cycle();
        rd_t r; logic [7:0] d0, d1, got;
        bus_wr(0, 4'd0, 8'h10);
        bus_cycle(1, 4'd0, 8'h99, 1, 4'd1, 8'h00);
        n_cmp++; if (b_pend0 !== 2'b01) begin n_bad++; $display("FAIL postack_pend: got %b expected 01", b_pend0); end
        n_cmp++; if (b_firq_n0 !== 1'b0) begin n_bad++; $display("FAIL postack_firq: got %b expected 0", b_firq_n0); end
        exp_rd(0, 1, 4'd1, 8'h80, "postack_status");
        exp_rd(0, 1, 4'd0, 8'h99, "postack_data");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(0, 4'd0, 8'hAA);
        exp_rd(0, 1, 4'd1, 8'hC0, "postack_then_ovf");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(1, 4'd1, 8'h00);
        // Both sides post on channel 0 simultaneously.
        bus_cycle(1, 4'd0, 8'h12, 1, 4'd0, 8'h34);
        n_cmp++; if ({a_pend0, b_pend0} !== 4'b0101) begin n_bad++; $display("FAIL dual_pend: got %b expected 0101", {a_pend0, b_pend0}); end
        exp_rd(0, 0, 4'd0, 8'h34, "dual_a_data");
        exp_rd(0, 1, 4'd0, 8'h12, "dual_b_data");
        exp_rd(0, 0, 4'd1, 8'hA0, "dual_a_status");
        exp_rd(0, 1, 4'd1, 8'hA0, "dual_b_status");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_cycle(1, 4'd1, 8'h00, 1, 4'd1, 8'h00);
        n_cmp++; if ({a_firq_n0, b_firq_n0, a_pend0, b_pend0} !== 6'b110000) begin
            n_bad++; $display("FAIL dual_ack: got %b expected 110000", {a_firq_n0, b_firq_n0, a_pend0, b_pend0});
        end
    endtask

    task automatic test_unmapped();
        rd_t r; logic [7:0] d0, d1, got;
        bus_wr(0, 4'd0, 8'h42);
        exp_rd(0, 0, 4'd5, 8'hFF, "unmap_a_rd5");
        exp_rd(0, 1, 4'd5, 8'hFF, "unmap_b_rd5");
        exp_rd(0, 0, 4'd15, 8'hFF, "unmap_a_rd15");
        exp_rd(0, 1, 4'd1, 8'h80, "rd_no_clear_1");
        exp_rd(0, 1, 4'd1, 8'h80, "rd_no_clear_2");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_cycle(1, 4'd5, 8'h00, 1, 4'd5, 8'h00);
        bus_cycle(1, 4'd7, 8'h00, 1, 4'd6, 8'h00);
        n_cmp++; if ({a_pend0, b_pend0} !== 4'b0001) begin n_bad++; $display("FAIL unmap_wr_pend: got %b expected 0001", {a_pend0, b_pend0}); end
        n_cmp++; if (b_firq_n0 !== 1'b0) begin n_bad++; $display("FAIL unmap_wr_firq: got %b expected 0", b_firq_n0); end
        n_cmp++; if ({a_dout0, b_dout0} !== 16'hFFFF) begin n_bad++; $display("FAIL cs_low_dout: got %04h expected ffff", {a_dout0, b_dout0}); end
        exp_rd(0, 1, 4'd4, 8'h03, "unmap_b_mask");
        exp_rd(0, 0, 4'd4, 8'h03, "unmap_a_mask");
        exp_rd(0, 1, 4'd0, 8'h42, "unmap_b_data");
        exp_rd(0, 0, 4'd1, 8'h20, "unmap_a_status");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(1, 4'd1, 8'h00);
    endtask

    task automatic test_pulse();
        rd_t r; logic [7:0] d0, d1, got;
        int n, it;
        do_reset();
        // Single post: 16 clocks low, level instance stays low.
        bus_wr(0, 4'd0, 8'h5A);
        n_cmp++; if (strb_b1 !== 1'b1) begin n_bad++; $display("FAIL pulse_strobe_cycle: got %b expected 1", strb_b1); end
        n = 0; it = 0;
        while (it < 200) begin
            if (b_firq_n1 === 1'b0) n++; else if (n > 0) break;
            it++; @(negedge clk);
        end
        n_cmp++; if (n != 16) begin n_bad++; $display("FAIL pulse_single_len: got %0d expected 16", n); end
        n_cmp++; if (b_firq_n0 !== 1'b0) begin n_bad++; $display("FAIL level_held: got %b expected 0", b_firq_n0); end
        bus_wr(1, 4'd1, 8'h00);
        // Retrigger 8 clocks into the pulse.
        bus_wr(0, 4'd0, 8'h01);
        n = 0; it = 0;
        fork
            begin
                while (it < 200) begin
                    if (b_firq_n1 === 1'b0) n++; else if (n > 0) break;
                    it++; @(negedge clk);
                end
            end
            begin
                repeat (5) @(negedge clk);
                bus_wr(0, 4'd2, 8'h02);
            end
        join
        n_cmp++; if (n != 24) begin n_bad++; $display("FAIL pulse_retrigger_len: got %0d expected 24", n); end
        bus_wr(1, 4'd1, 8'h00);
        bus_wr(1, 4'd3, 8'h00);
        // Ack during the pulse does not shorten it.
        bus_wr(0, 4'd0, 8'h03);
        n = 0; it = 0;
        fork
            begin
                while (it < 200) begin
                    if (b_firq_n1 === 1'b0) n++; else if (n > 0) break;
                    it++; @(negedge clk);
                end
            end
            bus_wr(1, 4'd1, 8'h00);
        join
        n_cmp++; if (n != 16) begin n_bad++; $display("FAIL pulse_ack_len: got %0d expected 16", n); end
        // Post to a masked channel gives no pulse.
        bus_wr(1, 4'd4, 8'h02);
        bus_wr(0, 4'd0, 8'h04);
        n = 0;
        repeat (20) begin
            if (b_firq_n1 === 1'b0) n++;
            @(negedge clk);
        end
        n_cmp++; if (n != 0) begin n_bad++; $display("FAIL pulse_masked: low for %0d expected 0", n); end
        exp_rd(1, 1, 4'd1, 8'h80, "pulse_masked_status");
        exp_rd(1, 1, 4'd0, 8'h04, "pulse_masked_data");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
        bus_wr(1, 4'd1, 8'h00);
        bus_wr(1, 4'd4, 8'h03);
        // Reset in the middle of a pulse.
        bus_wr(0, 4'd0, 8'h05);
        repeat (4) @(negedge clk);
        n_cmp++; if (b_firq_n1 !== 1'b0) begin n_bad++; $display("FAIL midpulse_low: got %b expected 0", b_firq_n1); end
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        n_cmp++; if ({b_firq_n1, b_pend1, a_pend1} !== 5'b10000) begin
            n_bad++; $display("FAIL midpulse_reset: got %b expected 10000", {b_firq_n1, b_pend1, a_pend1});
        end
        repeat (20) @(negedge clk);
        n_cmp++; if (b_firq_n1 !== 1'b1) begin n_bad++; $display("FAIL midpulse_no_resume: got %b expected 1", b_firq_n1); end
        exp_rd(1, 1, 4'd1, 8'h00, "mrst_b_stat0");
        exp_rd(1, 1, 4'd3, 8'h00, "mrst_b_stat1");
        exp_rd(1, 0, 4'd1, 8'h00, "mrst_a_stat0");
        exp_rd(1, 0, 4'd3, 8'h00, "mrst_a_stat1");
        exp_rd(1, 1, 4'd4, 8'h03, "mrst_b_mask");
        exp_rd(1, 1, 4'd0, 8'h00, "mrst_b_data");
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front(); bus_rd(r.side, r.addr, d0, d1); got = r.inst ? d1 : d0;
            n_cmp++; if (got !== r.exp) begin n_bad++; $display("FAIL %s: read %02h expected %02h", r.name, got, r.exp); end
        end
    endtask

    initial begin
        reset = 1;
        a_E = 0; a_cs = 0; a_rnw = 1; a_addr = '0; a_din = '0;
        b_E = 0; b_cs = 0; b_rnw = 1; b_addr = '0; b_din = '0;
        strb_b0 = 1'b1; strb_b1 = 1'b1;
        test_reset();
        test_post_ack();
        test_overflow();
        test_mask();
        test_same_cycle();
        test_unmapped();
        test_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
